// File: rtl/shift_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : shift_pkg                                             |
// | Purpose  : Shared types and constants for the shift-operator     |
// |            datapath and its serializer stage.                    |
// | Revision : 1.0  initial release                                  |
// +------------------------------------------------------------------+
package shift_pkg;

  // Serializer frame states; PARITY is only reachable with PARITY_EN.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  // Select encodings of the upstream shift-operator block.
  typedef enum logic [1:0] {
    SEL_SLL = 2'd0,
    SEL_SRL = 2'd1,
    SEL_SRA = 2'd2,
    SEL_ROL = 2'd3
  } shift_sel_t;

  // Default parallel width, matching the shift-operator output.
  localparam int DEFAULT_WIDTH = 4;

  // Bit counter width: must be able to hold the value WIDTH.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ser_bit_counter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : ser_bit_counter                                       |
// | Purpose  : Clear/enable data-bit counter with a terminal-count   |
// |            flag raised on the final data bit (WIDTH-1).          |
// | Revision : 1.0  initial release                                  |
// +------------------------------------------------------------------+
module ser_bit_counter
  import shift_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW = cnt_width(WIDTH);

  logic [CW-1:0] count;

  // Count accepted data bits; clear takes priority over enable.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + CW'(1);
    end
  end

  assign tc = (count == CW'(WIDTH - 1));

endmodule
`default_nettype wire

// File: rtl/shift_serializer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : shift_serializer                                      |
// | Purpose  : Captures a WIDTH-bit word over valid/ready and emits  |
// |            it one bit per transfer, flagging the final bit.      |
// |            Optional macro PARITY_EN appends an even-parity bit.  |
// | Revision : 1.0  initial release                                  |
// +------------------------------------------------------------------+
module shift_serializer
  import shift_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_out,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             ser_last,
  output logic             busy
);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] sreg_shifted;
  logic             data_bit;
  logic             accept;
  logic             xfer;
  logic             data_xfer;
  logic             tc;

  // Ready is gated by reset so a word offered during reset is never taken.
  assign in_ready  = (state == IDLE) && !rst;
  assign accept    = in_valid && in_ready;
  assign ser_valid = (state == SHIFT) || (state == PARITY);
  assign busy      = (state != IDLE);
  assign xfer      = ser_valid && ser_ready;
  assign data_xfer = xfer && (state == SHIFT);

  generate
    if (LSB_FIRST) begin : g_lsb_first
      assign data_bit     = sreg[0];
      assign sreg_shifted = {1'b0, sreg[WIDTH-1:1]};
    end else begin : g_msb_first
      assign data_bit     = sreg[WIDTH-1];
      assign sreg_shifted = {sreg[WIDTH-2:0], 1'b0};
    end
  endgenerate

  ser_bit_counter #(
    .WIDTH (WIDTH)
  ) u_bit_counter (
    .clk (clk),
    .rst (rst),
    .clr (accept),
    .en  (data_xfer),
    .tc  (tc)
  );

  // Frame state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: leave SHIFT only on the transfer of the final data bit.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (data_xfer && tc) begin
`ifdef PARITY_EN
          state_next = PARITY;
`else
          state_next = IDLE;
`endif
        end
      end
      PARITY: begin
`ifdef PARITY_EN
        if (xfer) begin
          state_next = IDLE;
        end
`else
        state_next = IDLE;
`endif
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Word capture on accept, one-position advance per data transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      sreg <= '0;
    end else if (accept) begin
      sreg <= in_data;
    end else if (data_xfer) begin
      sreg <= sreg_shifted;
    end
  end

`ifdef PARITY_EN
  logic par_bit;

  // Even parity of the word, frozen at accept so upstream may change.
  always_ff @(posedge clk) begin
    if (rst) begin
      par_bit <= 1'b0;
    end else if (accept) begin
      par_bit <= ^in_data;
    end
  end

  assign ser_out  = ((state == SHIFT) && data_bit) ||
                    ((state == PARITY) && par_bit);
  assign ser_last = (state == PARITY);
`else
  assign ser_out  = (state == SHIFT) && data_bit;
  assign ser_last = (state == SHIFT) && tc;
`endif

endmodule
`default_nettype wire

// File: tb/tb_shift_serializer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : tb_shift_serializer                                   |
// | Purpose  : Directed self-checking bench for shift_serializer;    |
// |            one LSB-first and one MSB-first instance share the    |
// |            stimulus. Honours PARITY_EN when defined.             |
// | Revision : 1.0  initial release                                  |
// +------------------------------------------------------------------+
module tb_shift_serializer;

`ifdef PARITY_EN
  localparam int FRAME = 5;
`else
  localparam int FRAME = 4;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] in_data;
  logic       in_valid;
  logic       ser_ready;

  logic in_ready_l, ser_out_l, ser_valid_l, ser_last_l, busy_l;
  logic in_ready_m, ser_out_m, ser_valid_m, ser_last_m, busy_m;

  // Selects which instance the checks observe.
  logic use_msb;
  logic in_ready, ser_out, ser_valid, ser_last, busy;

  assign in_ready  = use_msb ? in_ready_m  : in_ready_l;
  assign ser_out   = use_msb ? ser_out_m   : ser_out_l;
  assign ser_valid = use_msb ? ser_valid_m : ser_valid_l;
  assign ser_last  = use_msb ? ser_last_m  : ser_last_l;
  assign busy      = use_msb ? busy_m      : busy_l;

  int errors = 0;
  int checks = 0;

  shift_serializer #(.WIDTH(4), .LSB_FIRST(1'b1)) u_dut_lsb (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready_l),
    .ser_out   (ser_out_l),
    .ser_valid (ser_valid_l),
    .ser_ready (ser_ready),
    .ser_last  (ser_last_l),
    .busy      (busy_l)
  );

  shift_serializer #(.WIDTH(4), .LSB_FIRST(1'b0)) u_dut_msb (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready_m),
    .ser_out   (ser_out_m),
    .ser_valid (ser_valid_m),
    .ser_ready (ser_ready),
    .ser_last  (ser_last_m),
    .busy      (busy_m)
  );

  always #5 clk = ~clk;

  // Absolute time bound on the whole run.
  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish (got timeout, want finish)");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer a word for one accept edge; the bus is then scrambled.
  task automatic accept_word(input logic [3:0] word);
    in_data  = word;
    in_valid = 1'b1;
    #1;
    check_eq("in_ready_before_accept", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    in_data  = ~word;
  endtask

  // Observe nbits serial bits; optionally stall stall_len cycles before bit stall_at.
  task automatic stream(input logic [3:0] word, input int nbits, input int stall_at, input int stall_len);
    logic exp_bit;
    logic exp_last;
    for (int i = 0; i < nbits; i++) begin
      if (i < 4) begin
        exp_bit = use_msb ? word[3-i] : word[i];
      end else begin
        exp_bit = ^word;
      end
      exp_last = (i == FRAME - 1);
      if (i == stall_at) begin
        ser_ready = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          #1;
          check_eq("stall_valid", 32'(ser_valid), 32'd1);
          check_eq("stall_out", 32'(ser_out), 32'(exp_bit));
          check_eq("stall_last", 32'(ser_last), 32'(exp_last));
          tick();
        end
        ser_ready = 1'b1;
      end
      #1;
      check_eq($sformatf("valid[%0d]", i), 32'(ser_valid), 32'd1);
      check_eq($sformatf("out[%0d]", i), 32'(ser_out), 32'(exp_bit));
      check_eq($sformatf("last[%0d]", i), 32'(ser_last), 32'(exp_last));
      check_eq($sformatf("busy[%0d]", i), 32'(busy), 32'd1);
      check_eq($sformatf("in_ready_busy[%0d]", i), 32'(in_ready), 32'd0);
      tick();
    end
  endtask

  task automatic expect_idle(input string tag);
    #1;
    check_eq({tag, "_valid"}, 32'(ser_valid), 32'd0);
    check_eq({tag, "_out"}, 32'(ser_out), 32'd0);
    check_eq({tag, "_last"}, 32'(ser_last), 32'd0);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_in_ready"}, 32'(in_ready), 32'(!rst));
  endtask

  task automatic full_frame(input logic [3:0] word, input int stall_at, input int stall_len);
    accept_word(word);
    stream(word, FRAME, stall_at, stall_len);
    expect_idle("post_frame");
  endtask

  initial begin
    use_msb   = 1'b0;
    rst       = 1'b1;
    in_data   = 4'h0;
    in_valid  = 1'b0;
    ser_ready = 1'b1;
    tick();
    tick();

    // Reset state; in_ready held low while reset is asserted.
    expect_idle("reset");
    rst = 1'b0;
    #1;
    check_eq("in_ready_after_reset", 32'(in_ready), 32'd1);

    // LSB first: 0110 -> 0,1,1,0.
    full_frame(4'b0110, -1, 0);

    // MSB first: 1000 -> 1,0,0,0.
    use_msb = 1'b1;
    full_frame(4'b1000, -1, 0);
    use_msb = 1'b0;

    // Stall three cycles on the second bit of 1011 -> 1,1,0,1.
    full_frame(4'b1011, 1, 3);

    // Back-to-back offer: second word waits for the IDLE cycle.
    in_data  = 4'b0001;
    in_valid = 1'b1;
    tick();
    in_data  = 4'b1111;
    stream(4'b0001, FRAME, -1, 0);
    #1;
    check_eq("b2b_idle_valid", 32'(ser_valid), 32'd0);
    check_eq("b2b_idle_in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    in_data  = 4'b0000;
    stream(4'b1111, FRAME, -1, 0);
    expect_idle("b2b_end");

    // Reset after two bits of 0110: frame discarded.
    accept_word(4'b0110);
    stream(4'b0110, 2, -1, 0);
    rst = 1'b1;
    #1;
    check_eq("rst_in_ready_low", 32'(in_ready), 32'd0);
    tick();
    expect_idle("mid_rst");
    rst = 1'b0;
    #1;
    check_eq("mid_rst_release_ready", 32'(in_ready), 32'd1);
    full_frame(4'b1001, -1, 0);

    // Reset coinciding with a valid word: word is dropped.
    rst      = 1'b1;
    in_data  = 4'b1111;
    in_valid = 1'b1;
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    expect_idle("rst_vs_valid");

`ifdef PARITY_EN
    // Parity bits: 0111 -> parity 1, 0110 -> parity 0.
    full_frame(4'b0111, -1, 0);
    full_frame(4'b0110, 4, 2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
